forward_hazard_ctrl: RTL and testbench
======================================

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset. The reset port names and polarity follow the codebase convention and SHALL NOT change.
REQ-002 clk_i  in  1  system clock; all state changes on the rising edge.
REQ-003 rst_i  in  1  synchronous active-low reset.
REQ-004 id_valid_i  in  1  the ID-stage instruction is real, not a bubble.
REQ-005 id_rs1_i, id_rs2_i  in  5 each  ID-stage source register indices.
REQ-006 id_rd_i  in  5  ID-stage destination register index.
REQ-007 id_regwrite_i, id_memread_i  in  1 each  ID-stage writes a register / is a load.
REQ-008 flush_i  in  1  squash the ID-stage instruction (taken branch).
REQ-009 mem_busy_i  in  1  data memory not ready; whole pipeline must freeze.
REQ-010 fwd_a_o, fwd_b_o  out  2 each  forwarding select for the EX-stage operand A / B mux.
- 00 = register file; 01 = MEM/WB; 10 = EX/MEM; 11 is never driven.
REQ-011 stall_o  out  1  hold PC and IF/ID; insert a bubble into EX.
REQ-012 freeze_o  out  1  hold every pipeline register.
REQ-013 stall_cnt_o  out  16  saturating count of stall or freeze cycles.

Function
REQ-014 The block SHALL hold internal slots EX, MEM and WB. Each slot holds {valid, rd, regwrite, memread}.
REQ-015 A slot SHALL be "writing" when valid=1, regwrite=1 and rd!=0. Register x0 is never forwarded and never causes a stall.
REQ-016 Load-use hazard: stall_o SHALL be 1 combinationally when all of the following hold:
- state=RUN, id_valid_i=1, flush_i=0;
- the EX slot is writing with memread=1;
- EX.rd equals id_rs1_i or id_rs2_i.
REQ-017 FSM states SHALL be RUN and MEM_WAIT.
- RUN -> MEM_WAIT on the edge where mem_busy_i=1.
- MEM_WAIT -> RUN on the first edge where mem_busy_i=0.
- freeze_o SHALL be 1 iff state=MEM_WAIT or mem_busy_i=1.
REQ-018 When freeze_o=1, all slots and fwd_a_o/fwd_b_o SHALL hold their values, and stall_o SHALL be 0.
REQ-019 Otherwise, each edge SHALL shift WB<=MEM and MEM<=EX.
- EX <= a bubble (valid=0) if flush_i=1 or stall_o=1.
- Else EX <= the ID-stage fields.
REQ-020 Forwarding SHALL be computed at ID and registered with the EX load.
- fwd_a_o next = 10 if the EX slot is writing and EX.rd=id_rs1_i.
- Else 01 if the MEM slot is writing and MEM.rd=id_rs1_i.
- Else 00.
- fwd_b_o is identical using id_rs2_i.
REQ-021 When a bubble is loaded into EX, fwd_a_o and fwd_b_o SHALL be loaded with 00.
REQ-022 Forwarding latency SHALL be one cycle: the outputs are valid in the cycle the instruction occupies EX.
REQ-023 EX/MEM SHALL take priority over MEM/WB when both match, so the youngest producer wins.
REQ-024 flush_i and stall_o conditions in the same cycle: flush wins, stall_o=0, and a single bubble is inserted.
REQ-025 mem_busy_i and a load-use condition in the same cycle: freeze wins. The stall re-evaluates after the freeze ends.
REQ-026 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1 or freeze_o=1. It SHALL saturate at 16'hFFFF with no wrap.

Reset
REQ-027 When rst_i=0 at an edge, the following SHALL be cleared:
- all slot valid bits to 0;
- state to RUN;
- fwd_a_o and fwd_b_o to 00;
- stall_cnt_o to 0.
REQ-028 During reset, stall_o and freeze_o SHALL evaluate to 0 regardless of the ID inputs and mem_busy_i.
REQ-029 Reset asserted mid-freeze or mid-stall SHALL take priority and leave no residual hazard state.

Verification
REQ-030 EX forward: cycle 0 issues add x5 (rd=5, regwrite=1); cycle 1 issues sub with rs1=5 -> in cycle 2, fwd_a_o=10 and fwd_b_o=00.
REQ-031 MEM forward and priority:
- rd=7 producer, then a NOP, then a consumer with rs2=7 -> fwd_b_o=01.
- Two back-to-back writers of x7 followed by the consumer -> fwd_b_o=10.
REQ-032 Load-use: lw x3 is followed by add with rs1=3 -> stall_o=1 for exactly one cycle, and stall_cnt_o=1. The add then enters EX with fwd_a_o=01.
REQ-033 x0 and flush:
- A writer of rd=0 followed by a consumer with rs1=0 -> fwd_a_o=00 and stall_o=0.
- flush_i=1 during a load-use condition -> stall_o=0 and EX is loaded with a bubble.
REQ-034 Freeze: mem_busy_i=1 for 3 cycles -> freeze_o=1 for 4 cycles (including the MEM_WAIT exit), slots and fwd outputs held, and stall_cnt_o +4.
REQ-035 Saturation and reset:
- stall_cnt_o preloaded to FFFE, then 3 stall cycles -> FFFF.
- rst_i=0 mid-freeze -> the next cycle shows freeze_o=0, stall_cnt_o=0 and fwd outputs 00.

Source files
------------

// File: rtl/forward_hazard_ctrl.sv
// rtl/forward_hazard_ctrl.sv - EX-stage forwarding selects, load-use stall and memory-busy freeze
// Tracks EX/MEM/WB producers and registers operand selects as an instruction enters EX.
module forward_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        flush_i,
  input  logic        mem_busy_i,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        stall_o,
  output logic        freeze_o,
  output logic [15:0] stall_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  state_t      state_q, state_d;
  slot_t       ex_q, ex_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q, wb_d;
  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic bubble;

  // x0 is hard-wired zero, so it never forwards and never stalls
  function automatic logic produces(input slot_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input logic [4:0] r);
    if (produces(ex, r)) begin
      return FWD_EX;
    end else if (produces(mem, r)) begin
      return FWD_MEM;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    state_d     = state_q;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    freeze_o    = 1'b0;
    stall_o     = 1'b0;
    load_use    = 1'b0;
    bubble      = 1'b0;

    if (rst_i) begin
      freeze_o = (state_q == MEM_WAIT) || mem_busy_i;
      load_use = ex_q.memread && (produces(ex_q, id_rs1_i) || produces(ex_q, id_rs2_i));
      stall_o  = !freeze_o && (state_q == RUN) && id_valid_i && !flush_i && load_use;

      // Both states leave on the same condition: wait while memory is busy
      state_d = mem_busy_i ? MEM_WAIT : RUN;

      if ((stall_o || freeze_o) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end

      if (!freeze_o) begin
        wb_d   = mem_q;
        mem_d  = ex_q;
        bubble = flush_i || stall_o || !id_valid_i;
        if (bubble) begin
          ex_d    = '0;
          fwd_a_d = FWD_RF;
          fwd_b_d = FWD_RF;
        end else begin
          ex_d    = '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};
          fwd_a_d = fwd_sel(ex_q, mem_q, id_rs1_i);
          fwd_b_d = fwd_sel(ex_q, mem_q, id_rs2_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_o     = fwd_a_q;
  assign fwd_b_o     = fwd_b_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb/tb_forward_hazard_ctrl.sv - scoreboard bench for forward_hazard_ctrl
// Driver predicts each cycle's outputs from an instruction-history model; monitor compares at negedge.
module tb_forward_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_regwrite_i, id_memread_i;
  logic        flush_i, mem_busy_i;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        stall_o, freeze_o;
  logic [15:0] stall_cnt_o;

  forward_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .mem_busy_i(mem_busy_i),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o),
    .freeze_o(freeze_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       stall;
    logic       freeze;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  exp_t   sb[$];
  instr_t hist[$];   // in-flight instructions, youngest (EX) first
  logic   m_wait;
  logic [1:0]  m_fa, m_fb;
  logic [15:0] m_cnt;
  int errors = 0;
  int checks = 0;

  function automatic logic writer(input instr_t s, input logic [4:0] r);
    return s.v && s.rw && (s.rd != 0) && (s.rd == r);
  endfunction

  // Youngest producer of r among the two older instructions; EX/MEM=2, MEM/WB=1
  function automatic logic [1:0] producer(input logic [4:0] r);
    for (int i = 0; i < 2; i++)
      if (writer(hist[i], r)) return (i == 0) ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    instr_t z;
    z = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    hist = '{z, z, z};
    m_wait = 1'b0;
    m_fa = 2'd0;
    m_fb = 2'd0;
    m_cnt = 16'd0;
  endtask

  task automatic step(input logic r, input logic v, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic rw, input logic mr,
                      input logic fl, input logic bz);
    exp_t   e;
    instr_t n;
    logic   frz, stl, lu, bub;
    rst_i = r; id_valid_i = v; id_rs1_i = a; id_rs2_i = b; id_rd_i = d;
    id_regwrite_i = rw; id_memread_i = mr; flush_i = fl; mem_busy_i = bz;
    e.fa = m_fa; e.fb = m_fb; e.cnt = m_cnt;
    if (!r) begin
      e.stall = 1'b0; e.freeze = 1'b0;
      model_reset();
    end else begin
      frz = m_wait || bz;
      lu  = hist[0].mr && (writer(hist[0], a) || writer(hist[0], b));
      stl = !frz && v && !fl && lu;
      e.stall = stl; e.freeze = frz;
      if ((stl || frz) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_wait = bz;
      if (!frz) begin
        bub = fl || stl || !v;
        m_fa = bub ? 2'd0 : producer(a);
        m_fb = bub ? 2'd0 : producer(b);
        n = bub ? '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0} : '{v: 1'b1, rd: d, rw: rw, mr: mr};
        hist.push_front(n);
        void'(hist.pop_back());
      end
    end
    sb.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_o", int'(stall_o), int'(e.stall));
        chk("freeze_o", int'(freeze_o), int'(e.freeze));
        chk("fwd_a_o", int'(fwd_a_o), int'(e.fa));
        chk("fwd_b_o", int'(fwd_b_o), int'(e.fb));
        chk("stall_cnt_o", int'(stall_cnt_o), int'(e.cnt));
      end
    end
  end

  initial begin : driver
    rst_i = 0; id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    id_regwrite_i = 0; id_memread_i = 0; flush_i = 0; mem_busy_i = 0;
    @(posedge clk_i);
    #1;
    model_reset();
    step(0, 1, 1, 2, 3, 1, 1, 0, 1);
    nop();
    // EX forward: add x5 then sub rs1=5
    step(1, 1, 1, 2, 5, 1, 0, 0, 0);
    step(1, 1, 5, 0, 9, 1, 0, 0, 0);
    nop(); nop();
    // MEM forward, then EX/MEM priority
    step(1, 1, 1, 1, 7, 1, 0, 0, 0);
    nop();
    step(1, 1, 0, 7, 8, 1, 0, 0, 0);
    step(1, 1, 1, 1, 7, 1, 0, 0, 0);
    step(1, 1, 2, 2, 7, 1, 0, 0, 0);
    step(1, 1, 0, 7, 8, 1, 0, 0, 0);
    nop(); nop();
    // Load-use: lw x3 then add rs1=3 held in ID across the stall
    step(1, 1, 1, 0, 3, 1, 1, 0, 0);
    step(1, 1, 3, 4, 6, 1, 0, 0, 0);
    step(1, 1, 3, 4, 6, 1, 0, 0, 0);
    nop(); nop();
    // x0 writer/consumer, then flush during load-use
    step(1, 1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 2, 1, 0, 0, 0);
    step(1, 1, 1, 1, 4, 1, 1, 0, 0);
    step(1, 1, 4, 0, 6, 1, 0, 1, 0);
    nop(); nop();
    // Freeze: busy for three cycles with a load-use pending
    step(1, 1, 1, 1, 4, 1, 1, 0, 0);
    repeat (3) step(1, 1, 4, 0, 6, 1, 0, 0, 1);
    step(1, 1, 4, 0, 6, 1, 0, 0, 0);
    step(1, 1, 4, 0, 6, 1, 0, 0, 0);
    nop(); nop();
    // Reset mid-freeze
    step(1, 1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 1, 4, 4, 5, 1, 0, 0, 0);
    step(1, 1, 5, 0, 6, 1, 0, 0, 1);
    step(1, 1, 5, 0, 6, 1, 0, 0, 1);
    step(0, 1, 5, 0, 6, 1, 0, 0, 0);
    nop(); nop();
    // Randomized traffic over a small register set so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
    end
    // Saturation: run the counter past FFFF with a long freeze
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(); nop();
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
